guess_checker: RTL and testbench

//  Round controller for the binary guessing game; the consumer side of the target-number interface.
//  - Compares the player's switch value against the current target.
//  - Requires the match to be held stable before accepting it.
//  - Issues a one-cycle is_equal pulse that makes the generator latch a new target.
//  - Keeps score. Sits between the switch inputs, the target generator and the display logic.

---
 rtl/guess_checker.sv | 156 +++++++++++++++
 tb/tb_guess_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/guess_checker.sv
// Purpose : guessing-game round controller; accepts a guess once the synchronised switches match the target for HOLD_CYCLES cycles, then scores it.
// Latency : first matching guess_s cycle to is_equal = HOLD_CYCLES+1 cycles (+2 from the raw pin through the synchroniser).
// Backpr. : none; is_equal is a one-cycle request and the target generator must answer it on the following cycle.
// Option  : define ROUND_TIMER_EN for a per-round time limit (timeout/misses); undefined, both outputs stay 0.
module guess_checker #(
    parameter int WIDTH        = 8,
    parameter int HOLD_CYCLES  = 1000,
    parameter int SCORE_W      = 8,
    parameter int ROUND_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   target,
    input  logic [WIDTH-1:0]   guess,
    output logic               is_equal,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic               timeout,
    output logic               match,
    output logic               playing
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

    // EXPIRE is only reachable when the round timer is built in.
    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_HIT,
        S_SETTLE,
        S_EXPIRE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_g1;
    logic [WIDTH-1:0]   r_g2;
    logic               r_match;
    logic [HOLD_W-1:0]  r_hold;
    logic               r_settle;
    logic [SCORE_W-1:0] r_score;
    logic               w_hit;
    logic               w_expire;

    // A hold only completes while actively playing and still matching.
    assign w_hit = (r_state == S_PLAY) && r_match && (r_hold == HOLD_LAST);

    // Two-flop synchroniser on the switches, then a registered compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_g1    <= '0;
            r_g2    <= '0;
            r_match <= 1'b0;
        end else begin
            r_g1    <= guess;
            r_g2    <= r_g1;
            r_match <= (r_g2 == target);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and Moore outputs; the expiry check yields to a hit on the same cycle.
    always_comb begin
        w_next   = r_state;
        is_equal = 1'b0;
        timeout  = 1'b0;
        playing  = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:   if (start) w_next = S_PLAY;
            S_PLAY: begin
                if (w_hit)         w_next = S_HIT;
                else if (w_expire) w_next = S_EXPIRE;
            end
            S_HIT: begin
                is_equal = 1'b1;
                w_next   = S_SETTLE;
            end
            S_EXPIRE: begin
                is_equal = 1'b1;
`ifdef ROUND_TIMER_EN
                timeout  = 1'b1;
`endif
                w_next   = S_SETTLE;
            end
            S_SETTLE: if (r_settle) w_next = S_PLAY;
            default:  w_next = S_IDLE;
        endcase
    end

    // Consecutive-match counter; any mismatch or non-PLAY cycle restarts the hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if ((r_state == S_PLAY) && r_match) begin
            if (r_hold != HOLD_MAX) r_hold <= r_hold + HOLD_W'(1);
        end else begin
            r_hold <= '0;
        end
    end

    // SETTLE lasts two cycles: the generator updates one cycle after is_equal and the compare needs one more.
    always_ff @(posedge clk) begin
        if (rst)                      r_settle <= 1'b0;
        else if (r_state == S_SETTLE) r_settle <= ~r_settle;
        else                          r_settle <= 1'b0;
    end

    // Score counts accepted guesses and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst)                          r_score <= '0;
        else if (w_hit && (r_score != '1)) r_score <= r_score + SCORE_W'(1);
    end

    assign score = r_score;
    assign match = r_match;

`ifdef ROUND_TIMER_EN
    localparam int ROUND_W = $clog2(ROUND_CYCLES + 1);

    logic [ROUND_W-1:0] r_round;
    logic [SCORE_W-1:0] r_misses;

    assign w_expire = (r_state == S_PLAY) && (r_round == '0) && !w_hit;

    // Round timer: reload on every entry to PLAY, count down only while in PLAY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_round <= '0;
        end else if ((w_next == S_PLAY) && (r_state != S_PLAY)) begin
            r_round <= ROUND_W'(ROUND_CYCLES - 1);
        end else if ((r_state == S_PLAY) && (r_round != '0)) begin
            r_round <= r_round - ROUND_W'(1);
        end
    end

    // Miss counter for expired rounds, saturating.
    always_ff @(posedge clk) begin
        if (rst)                              r_misses <= '0;
        else if (w_expire && (r_misses != '1)) r_misses <= r_misses + SCORE_W'(1);
    end

    assign misses = r_misses;
`else
    assign w_expire = 1'b0;
    assign misses   = '0;
`endif

endmodule

// File: tb/tb_guess_checker.sv
module tb_guess_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] target;
    logic [7:0] guess;
    logic       is_equal;
    logic [7:0] score;
    logic [7:0] misses;
    logic       timeout;
    logic       match;
    logic       playing;

    guess_checker #(
        .WIDTH(8),
        .HOLD_CYCLES(4),
        .SCORE_W(8),
        .ROUND_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .target(target),
        .guess(guess),
        .is_equal(is_equal),
        .score(score),
        .misses(misses),
        .timeout(timeout),
        .match(match),
        .playing(playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int score;
        int to;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   exp_score = 0;
    int   n;
    logic prev_eq;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Expected accepted guess at cycle c; score model saturates at 255.
    task automatic push_hit(input int c);
        exp_t e;
        if (exp_score < 255) exp_score++;
        e.cyc   = c;
        e.score = exp_score;
        e.to    = 0;
        q.push_back(e);
    endtask

    task automatic push_expire(input int c);
        exp_t e;
        e.cyc   = c;
        e.score = exp_score;
        e.to    = 1;
        q.push_back(e);
    endtask

    // Output monitor: pops one expectation per is_equal pulse.
    always @(negedge clk) begin
        if (rst) begin
            prev_eq <= 1'b0;
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("pulse_missing_at", 32'(q[0].cyc), 32'(cyc));
                void'(q.pop_front());
            end
            if (timeout && !is_equal) chk("timeout_without_is_equal", 1, 0);
            if (is_equal) begin
                exp_t e;
                chk("no_back_to_back", 32'(prev_eq), 0);
                if (q.size() == 0) begin
                    chk("spurious_pulse", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    chk("pulse_score", 32'(score), 32'(e.score));
                    chk("pulse_timeout", 32'(timeout), 32'(e.to));
                end
            end
            prev_eq <= is_equal;
        end
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        guess  = 8'h00;
        target = 8'h3C;
        tick(3);
        chk("rst_score", 32'(score), 0);
        chk("rst_misses", 32'(misses), 0);
        chk("rst_is_equal", 32'(is_equal), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_playing", 32'(playing), 0);
        chk("rst_match", 32'(match), 0);
        rst = 1'b0;
        tick(2);
        chk("idle_without_start", 32'(playing), 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("playing_after_start", 32'(playing), 1);

        // Held match: pulse 7 cycles after the pin changes.
        n = cyc;
        guess = 8'h3C;
        push_hit(n + 7);
        tick(2);
        chk("match_not_yet", 32'(match), 0);
        tick(1);
        chk("match_rise", 32'(match), 1);
        tick(4);
        guess = 8'h00;
        tick(4);
        chk("score_after_first", 32'(score), 1);

        // Broken hold: 3 matches, one miss, then a fresh full hold.
        n = cyc;
        guess = 8'h3C;
        tick(3);
        guess = 8'h3D;
        tick(1);
        guess = 8'h3C;
        push_hit(n + 11);
        tick(7);
        guess = 8'h00;
        tick(4);
        chk("score_after_glitch", 32'(score), 2);

        // Guess still equal to the new target: next pulse after SETTLE + full hold.
        n = cyc;
        guess = 8'h3C;
        push_hit(n + 7);
        push_hit(n + 14);
        tick(7);
        target = 8'h3C;
        tick(2);
        chk("settle_playing", 32'(playing), 1);
        tick(5);
        guess = 8'h00;
        tick(4);

        // Fifth hit, then reset mid-round.
        n = cyc;
        guess = 8'h3C;
        push_hit(n + 7);
        tick(7);
        guess = 8'h00;
        tick(4);
        chk("score_before_reset", 32'(score), 5);
        rst = 1'b1;
        tick(1);
        chk("midrst_score", 32'(score), 0);
        chk("midrst_is_equal", 32'(is_equal), 0);
        chk("midrst_playing", 32'(playing), 0);
        tick(2);
        rst = 1'b0;
        exp_score = 0;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;

        // Saturation: continuous hits, one every 7 cycles, well past 255.
        n = cyc;
        guess = 8'h3C;
        for (int k = 0; k < 260; k++) push_hit(n + 7 + 7 * k);
        tick(7 * 260);
        guess = 8'h00;
        tick(4);
        chk("score_saturated", 32'(score), 255);

        // Guess never matches.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_score = 0;
        tick(1);
        n = cyc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
`ifdef ROUND_TIMER_EN
        push_expire(n + 21);
        tick(21);
        chk("misses_after_expiry", 32'(misses), 1);
        chk("score_after_expiry", 32'(score), 0);
        tick(1);
`else
        tick(60);
        chk("misses_no_timer", 32'(misses), 0);
        chk("score_no_timer", 32'(score), 0);
        chk("still_playing", 32'(playing), 1);
`endif

        chk("pending_pulses", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
